coin_tally_reporter: RTL and testbench

- Parametrised successor to the fixed 4-channel piggy-bank counter/UART path.
- Counts rising edges on NUM_CH pre-debounced coin inputs into saturating BCD counters of DIGITS digits each.
- Automatically transmits a consistent ASCII snapshot frame over an 8N1 UART whenever any count changes or a report is requested.
- Sits between the per-input debouncers and the top-level output pins.

---
 rtl/coin_tally_reporter_if.sv | 27 ++
 rtl/coin_tally_reporter.sv | 199 +++++++++++++++++++
 tb/tb_coin_tally_reporter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_tally_reporter_if.sv
// Coin tally reporter bus: coin/clear/report inputs and the
// live count, overflow and UART outputs.
interface coin_tally_reporter_if #(
    parameter int NUM_CH = 4,
    parameter int DIGITS = 3
);
    logic [NUM_CH-1:0]          coin_in;
    logic                       clear;
    logic                       report_req;
    logic [NUM_CH*DIGITS*4-1:0] counts_bcd;
    logic [NUM_CH-1:0]          overflow;
    logic                       tx_serial;
    logic                       tx_active;
    logic                       frame_done;

    modport master (
        output coin_in, clear, report_req,
        input  counts_bcd, overflow,
        input  tx_serial, tx_active, frame_done
    );

    modport slave (
        input  coin_in, clear, report_req,
        output counts_bcd, overflow,
        output tx_serial, tx_active, frame_done
    );
endinterface

// File: rtl/coin_tally_reporter.sv
// Saturating BCD coin counters with an 8N1 UART snapshot reporter.
// A frame is sent whenever a count changes, on clear or on request.
module coin_tally_reporter #(
    parameter int NUM_CH       = 4,
    parameter int DIGITS       = 3,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coin_tally_reporter_if.slave bus
);
    localparam int CW   = DIGITS * 4;
    localparam int FLEN = NUM_CH * DIGITS + NUM_CH + 1;
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(FLEN);
    localparam logic [CW-1:0] ALL9 = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    logic [NUM_CH-1:0]           r_sync1, r_sync2, r_prev;
    logic [NUM_CH-1:0]           w_edge;
    logic [NUM_CH-1:0][CW-1:0]   r_cnt;
    logic [NUM_CH-1:0]           r_ovf;
    logic                        r_pending;
    logic                        w_inc_any;
    state_t                      r_state, w_state_n;
    logic [TW-1:0]               r_tick, w_tick_n;
    logic [2:0]                  r_bit, w_bit_n;
    logic [BW-1:0]               r_byte, w_byte_n;
    logic [FLEN-1:0][7:0]        r_frame, w_frame;
    logic                        w_load;
    logic                        w_tick_end;
    logic                        w_last_byte;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= bus.coin_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_prev;

    always_comb begin
        w_inc_any = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_edge[ch] && r_cnt[ch] != ALL9) w_inc_any = 1'b1;
        end
    end

    // clear dominates: a coincident edge is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (bus.clear) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_edge[ch]) begin
                    if (r_cnt[ch] == ALL9) r_ovf[ch] <= 1'b1;
                    else r_cnt[ch] <= bcd_inc(r_cnt[ch]);
                end
            end
        end
    end

    // a new event in the LOAD cycle must survive for the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (bus.clear || bus.report_req || w_inc_any) begin
            r_pending <= 1'b1;
        end else if (w_load) begin
            r_pending <= 1'b0;
        end
    end

    always_comb begin
        w_frame = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int d = 0; d < DIGITS; d++) begin
                w_frame[ch*(DIGITS+1)+d] =
                    8'h30 + {4'h0, r_cnt[ch][(DIGITS-1-d)*4 +: 4]};
            end
            w_frame[ch*(DIGITS+1)+DIGITS] =
                (ch == NUM_CH - 1) ? 8'h0D : 8'h2C;
        end
        w_frame[FLEN-1] = 8'h0A;
    end

    assign w_tick_end  = (r_tick == TW'(CLKS_PER_BIT - 1));
    assign w_last_byte = (r_byte == BW'(FLEN - 1));

    always_comb begin
        w_state_n      = r_state;
        w_tick_n       = r_tick;
        w_bit_n        = r_bit;
        w_byte_n       = r_byte;
        w_load         = 1'b0;
        bus.tx_serial  = 1'b1;
        bus.tx_active  = 1'b0;
        bus.frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending) w_state_n = S_LOAD;
            end
            S_LOAD: begin
                w_load    = 1'b1;
                w_byte_n  = '0;
                w_tick_n  = '0;
                w_state_n = S_START;
            end
            S_START: begin
                bus.tx_serial = 1'b0;
                bus.tx_active = 1'b1;
                if (w_tick_end) begin
                    w_tick_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = S_DATA;
                end else begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            S_DATA: begin
                bus.tx_serial = r_frame[r_byte][r_bit];
                bus.tx_active = 1'b1;
                if (w_tick_end) begin
                    w_tick_n = '0;
                    if (r_bit == 3'd7) w_state_n = S_STOP;
                    else w_bit_n = r_bit + 3'd1;
                end else begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            S_STOP: begin
                bus.tx_active = 1'b1;
                if (w_tick_end) begin
                    w_tick_n = '0;
                    if (w_last_byte) begin
                        bus.frame_done = 1'b1;
                        w_state_n      = S_IDLE;
                    end else begin
                        w_byte_n  = r_byte + 1'b1;
                        w_state_n = S_START;
                    end
                end else begin
                    w_tick_n = r_tick + 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_n;
            r_tick  <= w_tick_n;
            r_bit   <= w_bit_n;
            r_byte  <= w_byte_n;
            if (w_load) r_frame <= w_frame;
        end
    end

    assign bus.counts_bcd = r_cnt;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_coin_tally_reporter.sv
// Randomised bench for coin_tally_reporter: integer count model
// plus a UART decoder comparing frames with the model snapshot.
module tb_coin_tally_reporter;
    localparam int NUM_CH = 4;
    localparam int DIGITS = 3;
    localparam int CLKS   = 4;
    localparam int FLEN   = NUM_CH * DIGITS + NUM_CH + 1;
    localparam int FW     = 8 * FLEN;
    localparam int MAXV   = 10 ** DIGITS - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    coin_tally_reporter_if #(.NUM_CH(NUM_CH), .DIGITS(DIGITS)) bus();

    coin_tally_reporter #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [FW-1:0] got,
                         input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int mc[NUM_CH];
    logic [NUM_CH-1:0] mo;

    function automatic void model_coin(input int ch);
        if (mc[ch] == MAXV) mo[ch] = 1'b1;
        else mc[ch] = mc[ch] + 1;
    endfunction

    function automatic void model_clear();
        for (int ch = 0; ch < NUM_CH; ch++) mc[ch] = 0;
        mo = '0;
    endfunction

    function automatic logic [FW-1:0] exp_counts();
        logic [FW-1:0] r;
        int p;
        r = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            p = 1;
            for (int d = 0; d < DIGITS; d++) begin
                r[ch*DIGITS*4 + d*4 +: 4] = 4'((mc[ch] / p) % 10);
                p = p * 10;
            end
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] exp_frame();
        logic [FW-1:0] f;
        int pos, p;
        f = '0;
        pos = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            p = 10 ** (DIGITS - 1);
            for (int d = 0; d < DIGITS; d++) begin
                f[pos*8 +: 8] = 8'(48 + (mc[ch] / p) % 10);
                p = p / 10;
                pos++;
            end
            f[pos*8 +: 8] = (ch == NUM_CH - 1) ? 8'h0D : 8'h2C;
            pos++;
        end
        f[pos*8 +: 8] = 8'h0A;
        return f;
    endfunction

    function automatic logic [FW-1:0] str_frame(input string s);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < s.len() && i < FLEN; i++) f[i*8 +: 8] = s[i];
        return f;
    endfunction

    // UART decoder and frame collector
    int rx_on = 0, rx_t = 0, cur_len = 0, act = 0, fd_cnt = 0;
    logic [7:0] rx_b;
    logic [FW-1:0] cur_f = '0;
    logic [FW-1:0] frames_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_on = 0;
            cur_len = 0;
            act = 0;
            cur_f = '0;
        end else begin
            if (bus.tx_active) act++;
            if (rx_on == 0) begin
                if (bus.tx_serial == 1'b0) begin
                    rx_on = 1;
                    rx_t = 0;
                end
            end else begin
                rx_t++;
                for (int k = 0; k < 8; k++)
                    if (rx_t == CLKS * (k + 1) + CLKS / 2)
                        rx_b[k] = bus.tx_serial;
                if (rx_t == CLKS * 9 + CLKS / 2) begin
                    check("stop_bit", FW'(bus.tx_serial), FW'(1));
                    if (cur_len < FLEN) cur_f[cur_len*8 +: 8] = rx_b;
                    cur_len++;
                    rx_on = 0;
                end
            end
            if (bus.frame_done) begin
                fd_cnt++;
                check("frm_len", FW'(cur_len), FW'(FLEN));
                check("frm_cycles", FW'(act), FW'(FLEN * 10 * CLKS));
                frames_q.push_back(cur_f);
                cur_len = 0;
                cur_f = '0;
                act = 0;
            end
        end
    end

    task automatic check_state(input string tag);
        check({tag, "_cnt"}, FW'(bus.counts_bcd), exp_counts());
        check({tag, "_ovf"}, FW'(bus.overflow), FW'(mo));
    endtask

    task automatic coin_pulse(input int ch, input int gap);
        bus.coin_in[ch] = 1'b1;
        model_coin(ch);
        repeat (2) @(negedge clk);
        bus.coin_in[ch] = 1'b0;
        repeat (2 + gap) @(negedge clk);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        model_clear();
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic pulse_report();
        bus.report_req = 1'b1;
        @(negedge clk);
        bus.report_req = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int t = 0;
        while (quiet < 12 && t < 4000) begin
            @(negedge clk);
            t++;
            if (bus.tx_active) quiet = 0;
            else quiet++;
        end
        check("idle_timeout", FW'(quiet >= 12), FW'(1));
    endtask

    task automatic wait_active();
        int t = 0;
        while (!bus.tx_active && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("active_timeout", FW'(bus.tx_active), FW'(1));
    endtask

    task automatic expect_frames(input string tag, input int lo,
                                 input int hi);
        int n;
        n = frames_q.size();
        check({tag, "_nfr"}, FW'(n >= lo && n <= hi), FW'(1));
        if (n > 0) check({tag, "_frm"}, frames_q[n-1], exp_frame());
        else check({tag, "_frm"}, '0, exp_frame());
        frames_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic flag;
        int fd0;
        logic [FW-1:0] exp0;
        bus.coin_in = '0;
        bus.clear = 1'b0;
        bus.report_req = 1'b0;
        model_clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", FW'(bus.tx_serial), FW'(1));
        check("rst_act", FW'(bus.tx_active), FW'(0));
        check("rst_fd", FW'(bus.frame_done), FW'(0));
        check_state("rst");
        rst_n = 1'b1;

        flag = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (bus.tx_serial !== 1'b1 || bus.tx_active || bus.frame_done)
                flag = 1'b1;
        end
        check("idle200", FW'(flag), FW'(0));
        check_state("idle200");
        check("idle200_nfr", FW'(frames_q.size()), FW'(0));

        // count latency: visible only after the third edge
        bus.coin_in[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_k1", FW'(bus.counts_bcd), '0);
        @(negedge clk);
        model_coin(1);
        check_state("lat_k2");
        bus.coin_in[1] = 1'b0;
        repeat (2) @(negedge clk);
        wait_idle();
        if (frames_q.size() > 0)
            check("ch1_literal", frames_q[0],
                  str_frame("000,001,000,000\r\n"));
        expect_frames("ch1", 1, 1);

        for (int i = 0; i < 1000; i++) coin_pulse(0, 0);
        wait_idle();
        check_state("sat");
        expect_frames("sat", 1, 100);
        pulse_clear();
        check_state("clr");
        wait_idle();
        expect_frames("clr", 1, 1);

        // events during a frame: old snapshot, then exactly one more frame
        pulse_report();
        wait_active();
        exp0 = exp_frame();
        for (int i = 0; i < 3; i++) coin_pulse(2, 0);
        wait_idle();
        check("mid_nfr", FW'(frames_q.size()), FW'(2));
        if (frames_q.size() >= 2) begin
            check("mid_frm0", frames_q[0], exp0);
            check("mid_frm1", frames_q[1], exp_frame());
            check("mid_literal", frames_q[1],
                  str_frame("000,000,003,000\r\n"));
        end
        frames_q.delete();

        bus.coin_in[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_clear();
        check_state("clr_vs_edge");
        repeat (3) @(negedge clk);
        bus.coin_in[3] = 1'b0;
        repeat (2) @(negedge clk);
        check_state("clr_vs_edge2");
        wait_idle();
        expect_frames("clr_vs_edge", 1, 1);

        coin_pulse(0, 0);
        wait_idle();
        frames_q.delete();
        pulse_report();
        wait_idle();
        check_state("report");
        expect_frames("report", 1, 1);

        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int a = 0; a < n; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 7) coin_pulse($urandom_range(0, NUM_CH - 1),
                                      $urandom_range(0, 5));
                else if (r < 9) pulse_report();
                else pulse_clear();
            end
            wait_idle();
            check_state("rnd");
            expect_frames("rnd", 1, 2);
        end

        coin_pulse(1, 0);
        wait_idle();
        frames_q.delete();
        pulse_report();
        wait_active();
        repeat (8) @(negedge clk);
        fd0 = fd_cnt;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check("rstmid_tx", FW'(bus.tx_serial), FW'(1));
        check("rstmid_act", FW'(bus.tx_active), FW'(0));
        check("rstmid_fd", FW'(bus.frame_done), FW'(0));
        check_state("rstmid");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.tx_serial !== 1'b1 || bus.tx_active || bus.frame_done)
                flag = 1'b1;
        end
        check("rstmid_idle", FW'(flag), FW'(0));
        check("rstmid_nfd", FW'(fd_cnt), FW'(fd0));
        check("rstmid_nfr", FW'(frames_q.size()), FW'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
